// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its sequential divider:
// divider FSM encoding, status-flag bit positions and ALU opcode constants.
package alu_pkg;

  // Divider controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Bit positions of the status flags in the ALU flag word
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEGATIVO = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_DIV_ZERO = 3;
  localparam int FLAG_OVERFLOW = 4;
  localparam int FLAG_COUNT    = 5;

  // ALU selector opcodes
  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_AND = 4'h2;
  localparam logic [3:0] ALU_OP_OR  = 4'h3;
  localparam logic [3:0] ALU_OP_XOR = 4'h4;
  localparam logic [3:0] ALU_OP_SHL = 4'h5;
  localparam logic [3:0] ALU_OP_SHR = 4'h6;
  localparam logic [3:0] ALU_OP_MUL = 4'h7;
  localparam logic [3:0] ALU_OP_DIV = 4'h8;

  // Width of the divider iteration counter for a given operand width
  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude if it fits.
module alu_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic         next_bit,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_next,
  output logic         quo_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Trial subtraction on W+1 bits; the top bit is the borrow (negative trial)
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    rem_next = '0;
    quo_bit  = 1'b0;
    shifted  = {rem, next_bit};
    trial    = shifted - {1'b0, divisor_mag};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_bit  = 1'b1;
    end else begin
      // Shifted remainder is below 2*|divisor| <= 2^W here, so it fits in W bits
      rem_next = shifted[W-1:0];
      quo_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/alu_divider.sv
// Sequential signed divider: magnitudes are divided by restoring
// shift-subtract, one quotient bit per cycle, then signs are applied.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module alu_divider
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  zero,
  output logic                  negativo,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = div_cnt_width(W);

  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q;      // partial remainder (raw dividend on a zero divisor)
  logic [W-1:0]  quo_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [W-1:0]  div_mag;    // |divisor|
  logic          sign_q;     // quotient must be negated
  logic          sign_r;     // remainder must be negated
  logic          ovf_pend;   // operands were most-negative / -1
  logic          div0_pend;  // operation was a division by zero

  logic [W-1:0]  dividend_mag;
  logic [W-1:0]  divisor_mag;
  logic [W-1:0]  step_rem;
  logic          step_bit;
  logic [W-1:0]  fix_quo;
  logic [W-1:0]  fix_rem;

  // Operand magnitudes as unsigned W-bit values; |most negative| = 2^(W-1) still fits
  always_comb begin
    dividend_mag = dividend[W-1] ? -dividend : dividend;
    divisor_mag  = divisor[W-1]  ? -divisor  : divisor;
  end

  alu_div_step #(
    .W(W)
  ) u_step (
    .rem        (rem_q),
    .next_bit   (quo_q[W-1]),
    .divisor_mag(div_mag),
    .rem_next   (step_rem),
    .quo_bit    (step_bit)
  );

  // Signed results from the unsigned magnitude quotient and remainder
  always_comb begin
    fix_quo = sign_q ? -quo_q : quo_q;
    fix_rem = sign_r ? -rem_q : rem_q;
  end

  // Controller: handshakes, iteration, sign fix-up and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_mag   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      ovf_pend  <= 1'b0;
      div0_pend <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      zero      <= 1'b0;
      negativo  <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            div_mag  <= divisor_mag;
            sign_q   <= dividend[W-1] ^ divisor[W-1];
            sign_r   <= dividend[W-1];
            ovf_pend <= (dividend == MOST_NEG) && (divisor == '1);
            cnt      <= '0;
            if (divisor == '0) begin
              // Zero divisor skips iteration; the fixed result is loaded next cycle
              div0_pend <= 1'b1;
              rem_q     <= dividend;
              quo_q     <= '0;
              state     <= ST_FIX;
            end else begin
              div0_pend <= 1'b0;
              rem_q     <= '0;
              quo_q     <= dividend_mag;
              state     <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[W-2:0], step_bit};
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (div0_pend) begin
            quotient  <= '1;
            remainder <= rem_q;
            zero      <= 1'b0;
            negativo  <= 1'b1;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else begin
            quotient  <= fix_quo;
            remainder <= fix_rem;
            zero      <= (fix_quo == '0);
            negativo  <= fix_quo[W-1];
            div_zero  <= 1'b0;
            overflow  <= ovf_pend;
          end
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          // Result registers hold their value after the handshake
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider (W=8): signed results, flags, latency,
// output back-pressure and reset during iteration.
module tb_alu_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       zero;
  logic       negativo;
  logic       div_zero;
  logic       overflow;

  logic [19:0] res;
  int vectors;
  int miscompares;

  alu_divider #(
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .zero     (zero),
    .negativo (negativo),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  // {quotient, remainder, zero, negativo, div_zero, overflow}
  assign res = {quotient, remainder, zero, negativo, div_zero, overflow};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operand pair; returns 1 ns after the accepting edge
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen, bounded at 40
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Consume the current result
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready, res} !== {1'b1 ^ 1'b1, 1'b1, 20'h0}) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b res=%h expected out_valid=0 in_ready=1 res=00000",
               out_valid, in_ready, res);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    apply(8'd100, 8'd7);
    wait_valid(lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles expected 9", lat);
    end
    vectors++;
    if (res !== {8'h0E, 8'h02, 4'b0000}) begin
      miscompares++;
      $display("FAIL basic_100_div_7: res=%h expected %h", res, {8'h0E, 8'h02, 4'b0000});
    end
    take();
  endtask

  task automatic test_signs();
    logic [7:0] a_tab [3] = '{8'h9C, 8'd100, 8'h9C};  // -100, 100, -100
    logic [7:0] b_tab [3] = '{8'd7, 8'hF9, 8'hF9};    // 7, -7, -7
    logic [19:0] e_tab [3] = '{{8'hF2, 8'hFE, 4'b0100},
                               {8'hF2, 8'h02, 4'b0100},
                               {8'h0E, 8'hFE, 4'b0000}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      apply(a_tab[i], b_tab[i]);
      wait_valid(lat);
      vectors++;
      if (res !== e_tab[i]) begin
        miscompares++;
        $display("FAIL signs_%0d: res=%h expected %h", i, res, e_tab[i]);
      end
      take();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    apply(8'd7, 8'd0);
    wait_valid(lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL div0_latency: got %0d cycles expected 1", lat);
    end
    vectors++;
    if (res !== {8'hFF, 8'h07, 4'b0110}) begin
      miscompares++;
      $display("FAIL div0_7: res=%h expected %h", res, {8'hFF, 8'h07, 4'b0110});
    end
    take();
    apply(8'hFB, 8'd0);  // -5 / 0
    wait_valid(lat);
    vectors++;
    if (res !== {8'hFF, 8'hFB, 4'b0110}) begin
      miscompares++;
      $display("FAIL div0_neg5: res=%h expected %h", res, {8'hFF, 8'hFB, 4'b0110});
    end
    take();
  endtask

  task automatic test_zero_quotient();
    int lat;
    apply(8'd3, 8'd5);
    wait_valid(lat);
    vectors++;
    if (res !== {8'h00, 8'h03, 4'b1000}) begin
      miscompares++;
      $display("FAIL zero_3_div_5: res=%h expected %h", res, {8'h00, 8'h03, 4'b1000});
    end
    take();
  endtask

  task automatic test_overflow();
    int lat;
    apply(8'h80, 8'hFF);  // -128 / -1
    wait_valid(lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL ovf_latency: got %0d cycles expected 9", lat);
    end
    vectors++;
    if (res !== {8'h80, 8'h00, 4'b0101}) begin
      miscompares++;
      $display("FAIL ovf_m128_div_m1: res=%h expected %h", res, {8'h80, 8'h00, 4'b0101});
    end
    take();
    apply(8'h80, 8'h01);  // -128 / 1
    wait_valid(lat);
    vectors++;
    if (res !== {8'h80, 8'h00, 4'b0100}) begin
      miscompares++;
      $display("FAIL m128_div_1: res=%h expected %h", res, {8'h80, 8'h00, 4'b0100});
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    apply(8'd20, 8'd3);
    wait_valid(lat);
    // Offer a second pair while the result is stalled
    dividend = 8'd9;
    divisor  = 8'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, res} !== {1'b1, 1'b0, 8'h06, 8'h02, 4'b0000}) begin
        miscompares++;
        $display("FAIL stall_cycle_%0d: out_valid=%b in_ready=%b res=%h expected 1 0 %h",
                 i, out_valid, in_ready, res, {8'h06, 8'h02, 4'b0000});
      end
    end
    take();
    vectors++;
    if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 8'h06, 8'h02, 4'b0000}) begin
      miscompares++;
      $display("FAIL release_to_idle: out_valid=%b in_ready=%b res=%h expected 0 1 %h",
               out_valid, in_ready, res, {8'h06, 8'h02, 4'b0000});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL next_accept: in_ready=%b expected 0", in_ready);
    end
    wait_valid(lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL next_latency: got %0d cycles expected 9", lat);
    end
    vectors++;
    if (res !== {8'h04, 8'h01, 4'b0000}) begin
      miscompares++;
      $display("FAIL next_9_div_2: res=%h expected %h", res, {8'h04, 8'h01, 4'b0000});
    end
    take();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    apply(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 20'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b res=%h expected 0 1 00000",
               out_valid, in_ready, res);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(8'd50, 8'd5);
    wait_valid(lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL after_reset_latency: got %0d cycles expected 9", lat);
    end
    vectors++;
    if (res !== {8'h0A, 8'h00, 4'b0000}) begin
      miscompares++;
      $display("FAIL after_reset_50_div_5: res=%h expected %h", res, {8'h0A, 8'h00, 4'b0000});
    end
    take();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_zero_quotient();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
